// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray/Binary conversion arbiter: FSM states,
// mode encodings and the completion-counter width.
package gray_conv_pkg;

    localparam int   COUNT_WIDTH = 16;
    localparam logic MODE_G2B    = 1'b0;
    localparam logic MODE_B2G    = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/gray_binary_convert_core.sv
// Combinational Gray<->Binary converter; the single datapath shared by all
// requesters of the arbiter.
module gray_binary_convert_core
    import gray_conv_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_mode,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [DATA_WIDTH-1:0] w_g2b;

    // Binary bit i is the XOR of every Gray bit from i up to the MSB
    always_comb begin
        w_g2b = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_g2b[i] = ^(i_data >> i);
        end
        if (i_mode == MODE_B2G) begin
            o_result = i_data ^ (i_data >> 1);
        end else begin
            o_result = w_g2b;
        end
    end

endmodule

// File: rtl/gray_binary_conversion_arbiter.sv
// Round-robin arbiter that time-shares one Gray<->Binary converter among
// N_REQ requesters and returns tagged, registered results.
module gray_binary_conversion_arbiter
    import gray_conv_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                        Clock_In,
    input  logic                        Reset_In,
    input  logic                        Enable_In,
    input  logic [N_REQ-1:0]            Req_Valid_In,
    input  logic [N_REQ-1:0]            Req_Mode_In,
    input  logic [N_REQ*DATA_WIDTH-1:0] Req_Data_In,
    output logic [N_REQ-1:0]            Req_Ready_Out,
    output logic                        Resp_Valid_Out,
    input  logic                        Resp_Ready_In,
    output logic [ID_WIDTH-1:0]         Resp_Id_Out,
    output logic [DATA_WIDTH-1:0]       Resp_Data_Out,
    output logic                        Busy_Out,
    output logic [COUNT_WIDTH-1:0]      Conv_Count_Out
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ID_WIDTH-1:0]     r_ptr;
    logic [ID_WIDTH-1:0]     r_id;
    logic                    r_mode;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_resp_valid;
    logic [ID_WIDTH-1:0]     r_resp_id;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic [COUNT_WIDTH-1:0]  r_count;

    logic [ID_WIDTH:0]       w_pick;
    logic                    w_pick_found;
    logic [ID_WIDTH-1:0]     w_pick_idx;
    logic                    w_grant;
    logic                    w_accept;
    logic [N_REQ-1:0]        w_ready;
    logic [DATA_WIDTH-1:0]   w_conv_result;

    // First valid index at or above ptr, wrapping; returns {found, index}.
    // A pointer outside 0..N_REQ-1 is treated as 0.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [N_REQ-1:0]    valid,
        input logic [ID_WIDTH-1:0] ptr
    );
        int                base;
        int                idx;
        logic [ID_WIDTH:0] res;
        res  = '0;
        base = (int'(ptr) < N_REQ) ? int'(ptr) : 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (base + k) % N_REQ;
            if (valid[idx]) begin
                res = {1'b1, ID_WIDTH'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_pick       = rr_pick(Req_Valid_In, r_ptr);
    assign w_pick_found = w_pick[ID_WIDTH];
    assign w_pick_idx   = w_pick[ID_WIDTH-1:0];

    gray_binary_convert_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_data   (r_data),
        .i_mode   (r_mode),
        .o_result (w_conv_result)
    );

    // Next-state and grant decode; grants only in IDLE and never during reset
    always_comb begin
        w_next_state = r_state;
        w_ready      = '0;
        w_grant      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Enable_In && w_pick_found && !Reset_In) begin
                    w_grant             = 1'b1;
                    w_ready[w_pick_idx] = 1'b1;
                    w_next_state        = CONVERT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CONVERT: begin
                w_next_state = RESPOND;
            end
            RESPOND: begin
                if (Resp_Ready_In) begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESPOND;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture, response registers, pointer advance and completion count
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_mode       <= MODE_G2B;
            r_data       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_count      <= '0;
        end else begin
            if (w_grant) begin
                r_id   <= w_pick_idx;
                r_mode <= Req_Mode_In[w_pick_idx];
                r_data <= Req_Data_In[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (r_state == CONVERT) begin
                r_resp_data  <= w_conv_result;
                r_resp_id    <= r_id;
                r_resp_valid <= 1'b1;
            end else if (w_accept) begin
                r_resp_valid <= 1'b0;
                r_ptr        <= (int'(r_id) >= N_REQ - 1) ? '0 : r_id + ID_WIDTH'(1);
                if (r_count != {COUNT_WIDTH{1'b1}}) begin
                    r_count <= r_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // Busy also covers the granting IDLE cycle so back-to-back work reads as continuous
    assign Busy_Out       = (r_state != IDLE) || w_grant;
    assign Req_Ready_Out  = w_ready;
    assign Resp_Valid_Out = r_resp_valid;
    assign Resp_Id_Out    = r_resp_id;
    assign Resp_Data_Out  = r_resp_data;
    assign Conv_Count_Out = r_count;

endmodule

// File: tb/tb_gray_binary_conversion_arbiter.sv
// Scoreboard bench for the Gray/Binary conversion arbiter: a cycle model
// predicts grants and pushes expected results, checked when the DUT responds.
module tb_gray_binary_conversion_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         rready;
    logic [N-1:0] vld;
    logic [N-1:0] mode;
    logic [N*W-1:0] data;
    logic [N-1:0] rdy;
    logic         rvalid;
    logic         busy;
    logic [1:0]   rid;
    logic [W-1:0] rdata;
    logic [15:0]  cnt;

    always #5 clk = ~clk;

    gray_binary_conversion_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (W),
        .ID_WIDTH   (2)
    ) dut (
        .Clock_In       (clk),
        .Reset_In       (rst),
        .Enable_In      (en),
        .Req_Valid_In   (vld),
        .Req_Mode_In    (mode),
        .Req_Data_In    (data),
        .Req_Ready_Out  (rdy),
        .Resp_Valid_Out (rvalid),
        .Resp_Ready_In  (rready),
        .Resp_Id_Out    (rid),
        .Resp_Data_Out  (rdata),
        .Busy_Out       (busy),
        .Conv_Count_Out (cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] d;
    } exp_t;

    exp_t        sb[$];
    int          grants[$];
    int          m_state    = 0;
    int          m_ptr      = 0;
    int          m_win      = 0;
    logic [15:0] m_cnt      = 16'd0;
    bit          m_rst_prev = 1'b0;

    function automatic logic [W-1:0] model_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        logic         acc;
        acc = 1'b0;
        b   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic logic [W-1:0] model_b2g(input logic [W-1:0] b);
        logic [W-1:0] g;
        for (int i = 0; i < W; i++) begin
            g[i] = (i == W - 1) ? b[i] : (b[i] ^ b[i+1]);
        end
        return g;
    endfunction

    // Cycle model + scoreboard, evaluated mid-cycle while inputs are stable
    always @(negedge clk) begin
        logic [N-1:0] e_rdy;
        int           w;
        exp_t         e;
        e_rdy = '0;
        if (m_rst_prev) begin
            chk("rst_resp_valid", 32'(rvalid), 32'd0);
            chk("rst_resp_id",    32'(rid),    32'd0);
            chk("rst_resp_data",  32'(rdata),  32'd0);
            chk("rst_count",      32'(cnt),    32'd0);
        end
        if (rst) begin
            chk("ready_in_rst", 32'(rdy), 32'd0);
            if (m_rst_prev) chk("busy_in_rst", 32'(busy), 32'd0);
            m_state = 0;
            m_ptr   = 0;
            m_cnt   = 16'd0;
            sb.delete();
        end else begin
            if (m_state == 0 && en && vld != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && vld[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                e_rdy[w] = 1'b1;
                m_win    = w;
                grants.push_back(w);
                e.id = 2'(w);
                e.d  = mode[w] ? model_b2g(data[w*W +: W]) : model_g2b(data[w*W +: W]);
                sb.push_back(e);
            end
            chk("ready",      32'(rdy),    32'(e_rdy));
            chk("busy",       32'(busy),   32'(m_state != 0 || e_rdy != '0));
            chk("resp_valid", 32'(rvalid), 32'(m_state == 2));
            chk("count",      32'(cnt),    32'(m_cnt));
            if (m_state == 2) begin
                if (sb.size() == 0) begin
                    chk("sb_depth", 32'(sb.size()), 32'd1);
                end else begin
                    chk("resp_id",   32'(rid),   32'(sb[0].id));
                    chk("resp_data", 32'(rdata), 32'(sb[0].d));
                    if (rready) void'(sb.pop_front());
                end
            end
            case (m_state)
                0: if (e_rdy != '0) m_state = 1;
                1: m_state = 2;
                2: if (rready) begin
                       m_state = 0;
                       m_ptr   = (m_win + 1) % N;
                       if (m_cnt != 16'hFFFF) m_cnt++;
                   end
                default: m_state = 0;
            endcase
        end
        m_rst_prev = rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic m, input logic [W-1:0] d);
        vld[idx]        = 1'b1;
        mode[idx]       = m;
        data[idx*W +: W] = d;
    endtask

    // Wait for any grant, then drop that requester's valid after the edge
    task automatic wait_grant_drop();
        bit           got;
        logic [N-1:0] g;
        got = 1'b0;
        g   = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rdy != '0) begin
                got = 1'b1;
                g   = rdy;
            end
        end
        chk("grant_seen", 32'(got), 32'd1);
        tick(1);
        vld = vld & ~g;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick(1);
            if (m_state == 0 && !rvalid) done = 1'b1;
        end
        chk("idle_seen", 32'(done), 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst    = 1'b1;
        en     = 1'b1;
        rready = 1'b1;
        vld    = '0;
        mode   = '0;
        data   = '0;
        do_reset(3);

        // single G->B request on requester 0
        set_req(0, 1'b0, 4'b1011);
        wait_grant_drop();
        wait_idle();

        // B->G on requester 2
        set_req(2, 1'b1, 4'b1101);
        wait_grant_drop();
        wait_idle();
        chk("count_two", 32'(cnt), 32'd2);

        // all requesters held valid from a fresh pointer
        do_reset(2);
        grants.delete();
        data = 16'h3C96;
        mode = 4'b1010;
        vld  = 4'b1111;
        tick(13);
        vld = '0;
        wait_idle();
        chk("rr_grants", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            chk("rr_order", 32'(grants[i]), 32'(exp_order[i]));
        end

        // consumer stalls five cycles in RESPOND while another request waits
        rready = 1'b0;
        set_req(1, 1'b0, 4'b0110);
        wait_grant_drop();
        set_req(3, 1'b1, 4'b1001);
        tick(6);
        rready = 1'b1;
        wait_grant_drop();
        wait_idle();

        // arbitration disabled with requests pending
        en = 1'b0;
        set_req(0, 1'b1, 4'b0011);
        set_req(2, 1'b0, 4'b1110);
        tick(6);
        en = 1'b1;
        wait_grant_drop();
        vld = '0;
        wait_idle();

        // enable drops while converting
        set_req(3, 1'b1, 4'b0111);
        wait_grant_drop();
        en = 1'b0;
        wait_idle();
        en = 1'b1;

        // reset in CONVERT discards the transaction and restarts the pointer
        do_reset(2);
        set_req(1, 1'b0, 4'b1111);
        wait_grant_drop();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("cnt_after_rst", 32'(cnt), 32'd0);
        grants.delete();
        set_req(1, 1'b0, 4'b0101);
        set_req(3, 1'b1, 4'b1010);
        wait_grant_drop();
        vld = '0;
        wait_idle();
        chk("rr_restart", 32'(grants.size() > 0 ? grants[0] : -1), 32'd1);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
